ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares the single RAMHelper port (one read channel, one write channel, 64-bit words) between the instruction-fetch requester (IF) and the load/store requester (LS) inside zerocore.
- Converts byte addresses to word indices and selects the 32-bit instruction half-word.
- Sequences every access with a one-outstanding request/response protocol.
- LS has priority over IF; a starvation counter bounds IF wait time.

Parameters:
- RAM_BASE, 64'h0000_0000_8000_0000, byte address that maps to RAM word index 0.
- STARVE_LIMIT, 4, consecutive LS grants allowed while IF is waiting before IF is forced a grant (range 1..15).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- if_req_valid  in  1  IF requests an instruction read
- if_req_ready  out  1  IF request accepted this cycle
- if_req_addr  in  64  IF byte address, 4-byte aligned
- if_resp_valid  out  1  one-cycle pulse; if_resp_inst valid
- if_resp_inst  out  32  fetched instruction
- ls_req_valid  in  1  LS request
- ls_req_ready  out  1  LS request accepted this cycle
- ls_req_wen  in  1  1 = write, 0 = read
- ls_req_addr  in  64  LS byte address, 8-byte aligned word access
- ls_req_wdata  in  64  write data
- ls_req_wmask  in  64  per-bit write mask
- ls_resp_valid  out  1  one-cycle pulse; read data or write ack
- ls_resp_rdata  out  64  read data (0 on write ack)
- ram_ren  out  1  RAMHelper read enable
- ram_ridx  out  64  read word index
- ram_rdata  in  64  read data, valid the cycle after ram_ren
- ram_wen  out  1  RAMHelper write enable
- ram_widx  out  64  write word index
- ram_wdata  out  64  write data
- ram_wmask  out  64  write mask

Behaviour:
- States:
  - IDLE: accept a request.
  - IF_RESP: deliver IF data.
  - LS_RESP: deliver LS data or ack.
- Reset values: state IDLE, starve_cnt 0, pend_half 0. All outputs 0: ready, resp_valid, ren, wen, idx, wdata, wmask, resp data.
- Ready/grant is combinational and asserted only in IDLE:
  - Only IF valid: grant IF.
  - Only LS valid: grant LS.
  - Both valid: grant LS, unless starve_cnt == STARVE_LIMIT, in which case grant IF.
  - At most one of if_req_ready / ls_req_ready is high in any cycle.
- Index = (addr - RAM_BASE) >> 3, 64-bit modular subtraction. Out-of-range addresses wrap and are not faulted.
- IF grant at cycle T:
  - ram_ren=1 and ram_ridx=index at T.
  - Latch pend_half = if_req_addr[2]; go to IF_RESP.
  - At T+1: if_resp_valid=1 and if_resp_inst = pend_half ? ram_rdata[63:32] : ram_rdata[31:0]; return to IDLE.
- LS read grant at T: ram_ren=1 at T; at T+1 ls_resp_valid=1, ls_resp_rdata=ram_rdata; return to IDLE.
- LS write grant at T:
  - ram_wen=1 at T with widx/wdata/wmask passed through; ram_ren=0.
  - At T+1: ls_resp_valid=1, ls_resp_rdata=0; return to IDLE.
- Latency and throughput: response exactly 1 cycle after grant. Maximum throughput is 1 access per 2 cycles. There is no response back-pressure; requesters must accept the pulse.
- ram_ren and ram_wen are never both 1 in a cycle. Outside a grant cycle, ren/wen=0 and the index, wdata and wmask outputs hold 0.
- resp data outputs are 0 whenever the corresponding resp_valid is 0.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each LS grant while if_req_valid=1.
  - Clears to 0 on any IF grant.
  - Clears to 0 on an LS grant while if_req_valid=0.
- Requester inputs are sampled only at the grant cycle. Changes to them during the RESP state are ignored.
- A request held valid through the RESP cycle is re-arbitrated in the following IDLE cycle.
- Reset mid-operation (rst=1 in IF_RESP or LS_RESP): the pending response is dropped (no resp_valid pulse), state returns to IDLE and starve_cnt is cleared, all in the same edge.
- A request asserted during reset is not granted until the first cycle with rst=0.

Test Plan:
- IF only, addr 0x8000_0004, ram_rdata 0x1111_2222_3333_4444 -> ram_ren=1 and ridx=0 at T; if_resp_valid at T+1 with inst 0x1111_2222. Repeat with addr 0x8000_0008 -> ridx=1, inst = low half.
- LS write addr 0x8000_0010, wdata 0xDEAD_BEEF, wmask all-ones -> ram_wen=1, widx=2 at T, ren=0; ls_resp_valid at T+1 with rdata 0.
- IF and LS both continuously valid, STARVE_LIMIT=4 -> grant sequence LS,LS,LS,LS,IF,LS,LS,LS,LS,IF; one grant every 2 cycles; ren and wen never coincide.
- LS read grant followed by rst=1 in the LS_RESP cycle -> no ls_resp_valid pulse; all outputs 0 and state IDLE next cycle; a request then proceeds normally.
- LS read accepted, ls_req_addr changes during LS_RESP -> response carries the data for the original index. No second grant occurs until IDLE.
- LS-only stream with IF idle -> starve_cnt stays 0. When IF asserts together with LS, LS wins the first 4 contended grants.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the IF/LS requester channels and the shared RAMHelper port.
// slave is the arbiter side; master is the requesters plus the RAM model.
interface ram_port_arbiter_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_resp_valid;
  logic [31:0] if_resp_inst;

  logic        ls_req_valid;
  logic        ls_req_ready;
  logic        ls_req_wen;
  logic [63:0] ls_req_addr;
  logic [63:0] ls_req_wdata;
  logic [63:0] ls_req_wmask;
  logic        ls_resp_valid;
  logic [63:0] ls_resp_rdata;

  logic        ram_ren;
  logic [63:0] ram_ridx;
  logic [63:0] ram_rdata;
  logic        ram_wen;
  logic [63:0] ram_widx;
  logic [63:0] ram_wdata;
  logic [63:0] ram_wmask;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_resp_valid, if_resp_inst,
    input  ls_req_valid, ls_req_wen, ls_req_addr, ls_req_wdata, ls_req_wmask,
    output ls_req_ready, ls_resp_valid, ls_resp_rdata,
    output ram_ren, ram_ridx, ram_wen, ram_widx, ram_wdata, ram_wmask,
    input  ram_rdata
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_resp_valid, if_resp_inst,
    output ls_req_valid, ls_req_wen, ls_req_addr, ls_req_wdata, ls_req_wmask,
    input  ls_req_ready, ls_resp_valid, ls_resp_rdata,
    input  ram_ren, ram_ridx, ram_wen, ram_widx, ram_wdata, ram_wmask,
    output ram_rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one RAMHelper read/write port between instruction fetch and load/store.
// One access outstanding at a time; LS wins ties until IF has waited STARVE_LIMIT grants.
module ram_port_arbiter #(
  parameter logic [63:0] RAM_BASE     = 64'h0000_0000_8000_0000,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  ram_port_arbiter_if.slave bus
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StIfResp, StLsResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        pend_half_q, pend_half_d;
  logic        ls_wr_q, ls_wr_d;

  logic        idle;
  logic        grant_if, grant_ls;
  logic [63:0] if_idx, ls_idx;

  assign if_idx = (bus.if_req_addr - RAM_BASE) >> 3;
  assign ls_idx = (bus.ls_req_addr - RAM_BASE) >> 3;

  // Grants are suppressed while rst is high so nothing is accepted during reset.
  always_comb begin
    idle     = (state_q == StIdle) && !rst;
    grant_ls = idle && bus.ls_req_valid && !(bus.if_req_valid && (starve_q == StarveMax));
    grant_if = idle && bus.if_req_valid && !grant_ls;
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    pend_half_d = pend_half_q;
    ls_wr_d     = ls_wr_q;
    unique case (state_q)
      StIdle: begin
        if (grant_if) begin
          state_d     = StIfResp;
          pend_half_d = bus.if_req_addr[2];
          starve_d    = 4'd0;
        end else if (grant_ls) begin
          state_d = StLsResp;
          ls_wr_d = bus.ls_req_wen;
          if (!bus.if_req_valid) begin
            starve_d = 4'd0;
          end else if (starve_q != StarveMax) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      StIfResp: state_d = StIdle;
      StLsResp: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.if_req_ready  = grant_if;
    bus.ls_req_ready  = grant_ls;
    bus.ram_ren       = 1'b0;
    bus.ram_ridx      = 64'd0;
    bus.ram_wen       = 1'b0;
    bus.ram_widx      = 64'd0;
    bus.ram_wdata     = 64'd0;
    bus.ram_wmask     = 64'd0;
    bus.if_resp_valid = 1'b0;
    bus.if_resp_inst  = 32'd0;
    bus.ls_resp_valid = 1'b0;
    bus.ls_resp_rdata = 64'd0;

    if (grant_if) begin
      bus.ram_ren  = 1'b1;
      bus.ram_ridx = if_idx;
    end else if (grant_ls && bus.ls_req_wen) begin
      bus.ram_wen   = 1'b1;
      bus.ram_widx  = ls_idx;
      bus.ram_wdata = bus.ls_req_wdata;
      bus.ram_wmask = bus.ls_req_wmask;
    end else if (grant_ls) begin
      bus.ram_ren  = 1'b1;
      bus.ram_ridx = ls_idx;
    end

    // A reset arriving in a response cycle drops the pulse.
    if (!rst && state_q == StIfResp) begin
      bus.if_resp_valid = 1'b1;
      bus.if_resp_inst  = pend_half_q ? bus.ram_rdata[63:32] : bus.ram_rdata[31:0];
    end
    if (!rst && state_q == StLsResp) begin
      bus.ls_resp_valid = 1'b1;
      bus.ls_resp_rdata = ls_wr_q ? 64'd0 : bus.ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      starve_q    <= 4'd0;
      pend_half_q <= 1'b0;
      ls_wr_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      pend_half_q <= pend_half_d;
      ls_wr_q     <= ls_wr_d;
    end
  end

endmodule
